uc_multiciclo: RTL
==================

// Module: uc_multiciclo
// PURPOSE
// - Multicycle control unit for polirv: replaces the single-cycle uc with a Moore FSM that sequences
//   fetch/decode/execute/memory/writeback over a shared datapath.
// - Handshakes with instruction and data memories that may insert wait states.
// - Flags illegal opcodes and bus timeouts; sits between the multicycle fd and the memories.
// PARAMETERS
// - OPCODE_BITS  7   width of opcode field taken from IR
// - MEM_TIMEOUT  16  max wait cycles per memory access before bus error; 0 = no timeout
// - CNT_BITS     32  width of performance counters (UC_PERF_CNT_EN only)
// PORTS
// - clk           in   1            clock, rising edge
// - rst_n         in   1            reset, asynchronous, active low
// - opcode        in   OPCODE_BITS  IR[6:0] from fd
// - funct3        in   3            IR[14:12]
// - funct7b5      in   1            IR[30]
// - alu_flags     in   4            from fd: 0 zero, 1 MSB, 2 overflow, 3 reserved
// - i_mem_ready   in   1            instruction word valid this cycle
// - d_mem_ready   in   1            data access complete this cycle
// - ir_we         out  1            load IR and old_pc
// - pc_we         out  1            load PC
// - pc_src        out  1            0: PC+4, 1: old_pc+imm
// - i_mem_re      out  1            instruction read request
// - d_mem_re      out  1            data read request
// - d_mem_we      out  1            data write request
// - rf_we         out  1            register file write
// - rf_src        out  1            0: ALU result reg, 1: data memory reg
// - alu_src       out  1            0: rf, 1: imm
// - alu_cmd       out  4            0000 and, 0001 or, 0010 add, 0110 sub
// - illegal       out  1            sticky: unknown opcode
// - bus_err       out  1            sticky: memory timeout
// BEHAVIOUR
// - Reset: state FETCH, all outputs 0, wait counter 0; counters 0.
// - States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs decoded from state (+ ready in FETCH/MEM).
// - FETCH: i_mem_re=1; when i_mem_ready: ir_we=1, pc_we=1, pc_src=0 same cycle, -> DECODE; else stay.
// - DECODE: no strobes; -> EXEC if opcode legal, else -> TRAP (illegal<=1).
//   Legal: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH.
// - EXEC: R: alu_cmd from funct3/funct7b5 (000/0 add, 000/1 sub, 111 and, 110 or), alu_src=0 -> WB.
//   I-ALU: same map, funct7b5 ignored (no subi), alu_src=1 -> WB.
//   LOAD/STORE: add, alu_src=1 -> MEM.
//   BRANCH: sub, alu_src=0; taken = (funct3==000 & zero)|(funct3==001 & !zero);
//   taken: pc_we=1, pc_src=1; -> FETCH. Other funct3 -> TRAP (illegal).
// - MEM: LOAD d_mem_re=1, STORE d_mem_we=1, held until d_mem_ready; then LOAD -> WB, STORE -> FETCH.
// - WB: rf_we=1, rf_src=1 for LOAD else 0; -> FETCH.
// - Latency (zero wait): BRANCH 3, R/I/STORE 4, LOAD 5 cycles.
// - Wait counter: clears on entering FETCH/MEM; increments each non-ready cycle.
//   MEM_TIMEOUT>0 and count reaches MEM_TIMEOUT-1 with no ready -> TRAP (bus_err<=1), request dropped.
//   Ready on that same cycle wins over timeout.
// - TRAP: all strobes 0, illegal/bus_err held; exits only via rst_n.
// - rst_n low mid-access: immediate return to reset state; any pending request dropped asynchronously.
// CONFIGURATION
// - UC_PERF_CNT_EN defined: adds outputs cycle_cnt[CNT_BITS] (+1 every cycle outside TRAP)
//   and instret_cnt[CNT_BITS] (+1 on every transition into FETCH from EXEC/MEM/WB).
//   Both wrap modulo 2^CNT_BITS, reset 0.
// - UC_PERF_CNT_EN undefined: ports and logic absent; FSM behaviour identical.
// STRUCTURE
// - Package polirv_pkg: opcode localparams, ALU_AND/OR/ADD/SUB codes, ALU flag indices,
//   state encoding.
// - Sub-module uc_alu_dec: combinational {opcode class, funct3, funct7b5} -> alu_cmd, alu_ok.
//   Shared with single-cycle uc.
// - Top holds FSM, wait counter, sticky flags, optional counters.
// TESTING
// - add x3,x1,x2 (R, funct7b5=0), readies tied 1 -> FETCH,DECODE,EXEC(alu_cmd 0010),WB(rf_we=1,rf_src=0); 4 cycles.
// - lw, i_mem_ready 2-cycle delay, d_mem_ready 3-cycle delay -> d_mem_re high 4 cycles,
//   rf_src=1 in WB; 10 cycles total.
// - beq with zero=1 -> EXEC pc_we=1,pc_src=1; with zero=0 -> pc_we=0 in EXEC; both 3 cycles.
// - opcode 1111111 -> TRAP after DECODE, illegal=1, all strobes 0 for 20 cycles; rst_n pulse -> FETCH.
// - MEM_TIMEOUT=4, sw with d_mem_ready stuck 0 -> bus_err=1 after 4 MEM cycles, d_mem_we drops.
//   Variant: ready on 4th cycle -> no error.
// - UC_PERF_CNT_EN: 3 back-to-back R instrs zero wait -> instret_cnt=3, cycle_cnt=12; CNT_BITS=4 wraps at 16.

Source files
------------

// File: rtl/polirv_pkg.sv
// Shared polirv control definitions: opcodes, ALU command codes, ALU flag indices,
// multicycle FSM states and the opcode classifier used by both control units.
package polirv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   localparam int unsigned FLAG_ZERO = 0;
   localparam int unsigned FLAG_MSB  = 1;
   localparam int unsigned FLAG_OVF  = 2;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } uc_state_e;

   typedef enum logic [2:0] {
      CLS_NONE,
      CLS_R,
      CLS_I,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH
   } op_class_e;

   function automatic op_class_e opcode_class(input logic [6:0] op);
      op_class_e cls;
      case (op)
         OP_R:      cls = CLS_R;
         OP_I:      cls = CLS_I;
         OP_LOAD:   cls = CLS_LOAD;
         OP_STORE:  cls = CLS_STORE;
         OP_BRANCH: cls = CLS_BRANCH;
         default:   cls = CLS_NONE;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/uc_alu_dec.sv
// ALU command decoder shared by the single-cycle and multicycle control units.
// alu_ok is low for encodings the datapath cannot execute.
module uc_alu_dec
   import polirv_pkg::*;
(
   input  op_class_e  op_class,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [3:0] alu_cmd,
   output logic       alu_ok
);

   always_comb begin
      alu_cmd = ALU_AND;
      alu_ok  = 1'b0;
      case (op_class)
         CLS_R, CLS_I: begin
            alu_ok = 1'b1;
            case (funct3)
               3'b000:  alu_cmd = (op_class == CLS_R && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b111:  alu_cmd = ALU_AND;
               3'b110:  alu_cmd = ALU_OR;
               default: alu_ok  = 1'b0;
            endcase
         end
         CLS_LOAD, CLS_STORE: begin
            alu_cmd = ALU_ADD;
            alu_ok  = 1'b1;
         end
         CLS_BRANCH: begin
            alu_cmd = ALU_SUB;
            alu_ok  = (funct3 == 3'b000) || (funct3 == 3'b001);
         end
         default: begin
            alu_cmd = ALU_AND;
            alu_ok  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle polirv control unit: FETCH/DECODE/EXEC/MEM/WB FSM with memory wait-state
// handshake, bus timeout and sticky error flags. Define UC_PERF_CNT_EN for perf counters.
module uc_multiciclo
   import polirv_pkg::*;
#(
   parameter int unsigned OPCODE_BITS = 7,
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_BITS    = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [OPCODE_BITS-1:0] opcode,
   input  logic [2:0]             funct3,
   input  logic                   funct7b5,
   input  logic [3:0]             alu_flags,
   input  logic                   i_mem_ready,
   input  logic                   d_mem_ready,
   output logic                   ir_we,
   output logic                   pc_we,
   output logic                   pc_src,
   output logic                   i_mem_re,
   output logic                   d_mem_re,
   output logic                   d_mem_we,
   output logic                   rf_we,
   output logic                   rf_src,
   output logic                   alu_src,
   output logic [3:0]             alu_cmd,
   output logic                   illegal,
   output logic                   bus_err
`ifdef UC_PERF_CNT_EN
   ,
   output logic [CNT_BITS-1:0]    cycle_cnt,
   output logic [CNT_BITS-1:0]    instret_cnt
`endif
);

   localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   uc_state_e         state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              illegal_q, illegal_d;
   logic              bus_err_q, bus_err_d;

   op_class_e  op_class;
   logic [3:0] dec_cmd;
   logic       dec_ok;
   logic       zero;
   logic       taken;
   logic       timeout;
   logic       unused_flags;

   assign op_class     = opcode_class(7'(opcode));
   assign zero         = alu_flags[FLAG_ZERO];
   assign taken        = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
   assign timeout      = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);
   assign unused_flags = ^{alu_flags[FLAG_MSB], alu_flags[FLAG_OVF], alu_flags[3]};

   uc_alu_dec u_alu_dec (
      .op_class (op_class),
      .funct3   (funct3),
      .funct7b5 (funct7b5),
      .alu_cmd  (dec_cmd),
      .alu_ok   (dec_ok)
   );

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 1'b0;
      i_mem_re  = 1'b0;
      d_mem_re  = 1'b0;
      d_mem_we  = 1'b0;
      rf_we     = 1'b0;
      rf_src    = 1'b0;
      alu_src   = 1'b0;
      alu_cmd   = ALU_AND;

      case (state_q)
         S_FETCH: begin
            i_mem_re = 1'b1;
            if (i_mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_DECODE;
            end else if (timeout) begin
               bus_err_d = 1'b1;
               state_d   = S_TRAP;
            end
         end
         S_DECODE: begin
            if (op_class != CLS_NONE) begin
               state_d = S_EXEC;
            end else begin
               illegal_d = 1'b1;
               state_d   = S_TRAP;
            end
         end
         S_EXEC: begin
            alu_cmd = dec_cmd;
            alu_src = (op_class == CLS_I) || (op_class == CLS_LOAD) || (op_class == CLS_STORE);
            if (!dec_ok) begin
               illegal_d = 1'b1;
               state_d   = S_TRAP;
            end else begin
               case (op_class)
                  CLS_R, CLS_I:        state_d = S_WB;
                  CLS_LOAD, CLS_STORE: state_d = S_MEM;
                  CLS_BRANCH: begin
                     pc_we   = taken;
                     pc_src  = taken;
                     state_d = S_FETCH;
                  end
                  default: begin
                     illegal_d = 1'b1;
                     state_d   = S_TRAP;
                  end
               endcase
            end
         end
         S_MEM: begin
            d_mem_re = (op_class == CLS_LOAD);
            d_mem_we = (op_class != CLS_LOAD);
            if (d_mem_ready) begin
               state_d = (op_class == CLS_LOAD) ? S_WB : S_FETCH;
            end else if (timeout) begin
               bus_err_d = 1'b1;
               state_d   = S_TRAP;
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            rf_src  = (op_class == CLS_LOAD);
            state_d = S_FETCH;
         end
         default: begin
            state_d = S_TRAP;
         end
      endcase

      // Any state change clears the wait count, so it always starts at 0 in FETCH/MEM.
      if (state_d != state_q) begin
         wait_d = '0;
      end else if ((state_q == S_FETCH && !i_mem_ready) || (state_q == S_MEM && !d_mem_ready)) begin
         wait_d = wait_q + 1'b1;
      end

      // Strobes fall with rst_n itself, not at the next edge.
      if (!rst_n) begin
         ir_we    = 1'b0;
         pc_we    = 1'b0;
         pc_src   = 1'b0;
         i_mem_re = 1'b0;
         d_mem_re = 1'b0;
         d_mem_we = 1'b0;
         rf_we    = 1'b0;
         rf_src   = 1'b0;
         alu_src  = 1'b0;
         alu_cmd  = ALU_AND;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign illegal = illegal_q;
   assign bus_err = bus_err_q;

`ifdef UC_PERF_CNT_EN
   logic [CNT_BITS-1:0] cycle_q, cycle_d;
   logic [CNT_BITS-1:0] instret_q, instret_d;

   always_comb begin
      cycle_d   = cycle_q;
      instret_d = instret_q;
      if (state_q != S_TRAP) begin
         cycle_d = cycle_q + 1'b1;
      end
      if (state_d == S_FETCH && (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB)) begin
         instret_d = instret_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         cycle_q   <= cycle_d;
         instret_q <= instret_d;
      end
   end

   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;
`else
   localparam int unsigned unused_cnt_bits = CNT_BITS;
`endif

endmodule
